uart_event_reporter: RTL
========================

// Module: uart_event_reporter
// PURPOSE
//  Transmit-side counterpart of the UART/button command front end. Accepts game events
//  (executed command, score update, game over) from the game core. Buffers them in a FIFO
//  and serialises each one as an ASCII line into the shared uart transmitter.
//  Command echoes use the same key letters the receiver accepts, so a host can replay the log.
// PARAMETERS
//  DEPTH       8     event FIFO entries; must be a power of 2, >= 2
//  TX_TIMEOUT  1024  cycles to wait for is_transmitting to rise after transmit before retrying the byte
// PORTS
//  clk              in   1   clock
//  reset_n          in   1   reset, synchronous, active-low
//  ev_valid         in   1   event offered this cycle
//  ev_kind          in   2   report_kind_t: REP_CMD / REP_SCORE / REP_OVER
//  ev_cmd           in   state_type  command payload; used only when ev_kind = REP_CMD
//  ev_arg           in   16  score payload; used only when ev_kind = REP_SCORE
//  ev_ready         out  1   event accepted when ev_valid & ev_ready
//  is_transmitting  in   1   from uart: serialiser busy
//  transmit         out  1   to uart: one-cycle start strobe
//  tx_byte          out  8   to uart: byte; valid while transmit = 1
//  busy             out  1   FIFO non-empty or message in progress
// BEHAVIOUR
//  Reset: ev_ready=1, transmit=0, tx_byte=8'h00, busy=0, FIFO empty, FSM in IDLE, counters cleared.
//  Enqueue
//   - ev_ready = !full; ev_ready is computed from the registered count only, never from ev_valid.
//   - REP_CMD with ev_cmd outside {LEFT,RIGHT,DOWN,DROP,HOLD,ROTATE,ROTATE_REV}: accepted (handshake completes), not stored.
//   - Push and pop in the same cycle: count unchanged. A push while full cannot occur, because ev_ready=0.
//  Message formats (ASCII, hex digits upper case, most significant digit first)
//   - REP_CMD: tag, CR, LF. Tags: LEFT 'A', RIGHT 'D', DOWN 'W', DROP 'S', HOLD 'C', ROTATE 'X', ROTATE_REV 'Z'.
//   - REP_SCORE: 'P', 4 hex digits of ev_arg, CR, LF (7 bytes).
//   - REP_OVER: 'G', CR, LF.
//  FSM states: IDLE -> LOAD -> SEND -> WAIT_BUSY -> WAIT_IDLE -> (SEND | IDLE)
//   - IDLE: when the FIFO is non-empty and is_transmitting=0, pop the head into the message register; go to LOAD.
//   - LOAD: byte index <- 0, last index <- 2 or 6 depending on kind.
//   - SEND: present the byte for the current index on tx_byte; transmit=1 for exactly this one cycle.
//   - WAIT_BUSY: wait until is_transmitting=1. If TX_TIMEOUT cycles elapse first, return to SEND with the same index.
//   - WAIT_IDLE: wait until is_transmitting=0.
//     * Index below last: increment the index and go to SEND.
//     * Otherwise: go to IDLE.
//   - Outside SEND: transmit=0. tx_byte holds its last value.
//  Timing and ordering
//   - Latency: accepted event into an empty FIFO with an idle uart gives the first transmit strobe 3 cycles later.
//   - Messages are never interleaved. Events are emitted strictly in acceptance order.
//   - The message register is a snapshot taken at pop. Later events never corrupt the line in flight.
//  Reset mid-message: the line is abandoned. The uart is reset by the same reset_n, so no partial byte is resumed.
//  Widths: hex digit d maps to 8'h30+d for d<10 and 8'h37+d otherwise. Pointers wrap modulo DEPTH. The count is $clog2(DEPTH)+1 bits.
// STRUCTURE
//  - enum_type package gains:
//    * typedef enum logic [1:0] {REP_CMD, REP_SCORE, REP_OVER, REP_RSVD} report_kind_t;
//    * localparams for the tag characters, CR (8'h0D) and LF (8'h0A).
//  - Sub-module report_fifo #(DEPTH, W):
//    * synchronous FIFO with push, pop, full, empty and head data, no fall-through;
//    * entry = {kind, tag byte, arg}, with the tag resolved at enqueue.
//  - The top level holds the tag mapping, the FSM, the byte mux and the timeout counter.
// TESTING
//  1. ev_kind=REP_CMD, ev_cmd=ROTATE, uart model idle -> strobes carry 8'h58, 8'h0D, 8'h0A, in order; busy returns to 0.
//  2. REP_SCORE, ev_arg=16'h0A3F -> bytes "P0A3F\r\n" (50 30 41 33 46 0D 0A).
//  3. Push 9 events back to back with DEPTH=8 and the uart held busy -> ev_ready=0 after the 8th; the 9th is held until the first pop; all 9 lines arrive in order.
//  4. REP_CMD with ev_cmd=NONE -> handshake completes, no transmit strobe, busy stays 0.
//  5. uart model ignores the first strobe (is_transmitting stays 0) -> after TX_TIMEOUT, the same byte is re-strobed; the line completes intact.
//  6. reset_n=0 asserted during byte 3 of a score line -> next cycle transmit=0, ev_ready=1, busy=0; a subsequent event yields a clean full line.

Source files
------------

// File: rtl/uart_event_reporter_pkg.sv
// Shared types for the UART event reporter: command codes, report kinds, FSM states.
// Also holds the ASCII tag characters and line terminators used on the wire.
// hex_ascii() turns a nibble into its upper-case ASCII hex digit.
package uart_event_reporter_pkg;

    // Command codes shared with the receive-side front end; NONE means "no command".
    typedef enum logic [2:0] {
        NONE,
        LEFT,
        RIGHT,
        DOWN,
        DROP,
        HOLD,
        ROTATE,
        ROTATE_REV
    } state_type;

    typedef enum logic [1:0] {
        REP_CMD,
        REP_SCORE,
        REP_OVER,
        REP_RSVD
    } report_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE
    } rep_fsm_t;

    // Command echo tags match the receiver's key letters so a log can be replayed.
    localparam logic [7:0] TAG_LEFT       = 8'h41; // 'A'
    localparam logic [7:0] TAG_RIGHT      = 8'h44; // 'D'
    localparam logic [7:0] TAG_DOWN       = 8'h57; // 'W'
    localparam logic [7:0] TAG_DROP       = 8'h53; // 'S'
    localparam logic [7:0] TAG_HOLD       = 8'h43; // 'C'
    localparam logic [7:0] TAG_ROTATE     = 8'h58; // 'X'
    localparam logic [7:0] TAG_ROTATE_REV = 8'h5A; // 'Z'
    localparam logic [7:0] TAG_SCORE      = 8'h50; // 'P'
    localparam logic [7:0] TAG_OVER       = 8'h47; // 'G'
    localparam logic [7:0] CHAR_CR        = 8'h0D;
    localparam logic [7:0] CHAR_LF        = 8'h0A;

    // One queued event; the tag byte is resolved when the event is accepted.
    typedef struct packed {
        report_kind_t kind;
        logic [7:0]   tag;
        logic [15:0]  arg;
    } rep_entry_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

endpackage

// File: rtl/uart_event_reporter_fifo.sv
// Generic synchronous FIFO holding queued report entries; no fall-through.
// Latency: a push is visible at head_dat one cycle later. Backpressure: full blocks push.
// Ports: clk/reset_n, push+push_dat, pop, full, empty, head_dat (entry at the read pointer).
module report_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign head_dat = mem_q[rd_ptr_q];

    // Guard against misuse so the count can never run past its bounds.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1); // power-of-2 depth: wraps naturally
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_event_reporter.sv
// Queues game events and serialises each as an ASCII line ("X\r\n", "P0A3F\r\n", "G\r\n") to the uart.
// Latency: event into empty FIFO with idle uart -> first transmit strobe 3 cycles later.
// Backpressure: ev_ready = !full (registered count only); each byte waits for the uart busy/idle cycle.
// Ports: ev_valid/ev_kind/ev_cmd/ev_arg/ev_ready (event in), is_transmitting (uart busy),
//        transmit/tx_byte (uart start strobe + byte), busy (work pending or line in flight).
module uart_event_reporter
    import uart_event_reporter_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int TX_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ev_valid,
    input  report_kind_t ev_kind,
    input  state_type    ev_cmd,
    input  logic [15:0]  ev_arg,
    output logic         ev_ready,
    input  logic         is_transmitting,
    output logic         transmit,
    output logic [7:0]   tx_byte,
    output logic         busy
);

    localparam int              TW       = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TX_TIMEOUT - 1);

    rep_fsm_t      state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    last_q, last_d;
    rep_entry_t    msg_q, msg_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          transmit_q, transmit_d;
    logic [7:0]    tx_byte_q, tx_byte_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          fifo_push;
    rep_entry_t    fifo_head;
    rep_entry_t    enq_entry;
    logic [7:0]    enq_tag;
    logic          enq_storable;

    // Byte at position i of the line described by m.
    function automatic logic [7:0] msg_byte(input rep_entry_t m, input logic [2:0] i);
        logic [7:0] b;
        b = CHAR_LF;
        if (i == 3'd0) begin
            b = m.tag;
        end else if (m.kind == REP_SCORE) begin
            case (i)
                3'd1:    b = hex_ascii(m.arg[15:12]);
                3'd2:    b = hex_ascii(m.arg[11:8]);
                3'd3:    b = hex_ascii(m.arg[7:4]);
                3'd4:    b = hex_ascii(m.arg[3:0]);
                3'd5:    b = CHAR_CR;
                default: b = CHAR_LF;
            endcase
        end else begin
            b = (i == 3'd1) ? CHAR_CR : CHAR_LF;
        end
        return b;
    endfunction

    // Tag lookup at enqueue. Unknown commands and the reserved kind are
    // handshaken but dropped, so they never occupy a FIFO slot.
    always_comb begin
        enq_tag      = 8'h00;
        enq_storable = 1'b0;
        case (ev_kind)
            REP_CMD: begin
                enq_storable = 1'b1;
                case (ev_cmd)
                    LEFT:       enq_tag = TAG_LEFT;
                    RIGHT:      enq_tag = TAG_RIGHT;
                    DOWN:       enq_tag = TAG_DOWN;
                    DROP:       enq_tag = TAG_DROP;
                    HOLD:       enq_tag = TAG_HOLD;
                    ROTATE:     enq_tag = TAG_ROTATE;
                    ROTATE_REV: enq_tag = TAG_ROTATE_REV;
                    default:    enq_storable = 1'b0;
                endcase
            end
            REP_SCORE: begin
                enq_storable = 1'b1;
                enq_tag      = TAG_SCORE;
            end
            REP_OVER: begin
                enq_storable = 1'b1;
                enq_tag      = TAG_OVER;
            end
            default: enq_storable = 1'b0;
        endcase
    end

    assign enq_entry = '{kind: ev_kind,
                         tag:  enq_tag,
                         arg:  (ev_kind == REP_SCORE) ? ev_arg : 16'h0000};

    assign ev_ready  = ~fifo_full;
    assign fifo_push = ev_valid & ev_ready & enq_storable;

    report_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(rep_entry_t))
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat (enq_entry),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (fifo_head)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        msg_d    = msg_q;
        tmo_d    = tmo_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Snapshot the head so later events cannot disturb the line in flight.
                if (!fifo_empty && !is_transmitting) begin
                    fifo_pop = 1'b1;
                    msg_d    = fifo_head;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_d   = 3'd0;
                last_d  = (msg_q.kind == REP_SCORE) ? 3'd6 : 3'd2;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                tmo_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A strobe the uart never acknowledged is retried with the same index.
                if (is_transmitting) begin
                    state_d = ST_WAIT_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_SEND;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (!is_transmitting) begin
                    if (idx_q < last_q) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered: the strobe is high exactly while in SEND,
        // and tx_byte keeps its last value between strobes.
        transmit_d = (state_d == ST_SEND);
        tx_byte_d  = transmit_d ? msg_byte(msg_d, idx_d) : tx_byte_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            msg_q      <= '0;
            tmo_q      <= '0;
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            msg_q      <= msg_d;
            tmo_q      <= tmo_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign transmit = transmit_q;
    assign tx_byte  = tx_byte_q;
    assign busy     = ~fifo_empty | (state_q != ST_IDLE);

endmodule
